arb_requester: RTL and testbench

Requester-side agent for the 4-way priority-lock arbiter; one instance per requester bit. It accepts queued burst commands from a client, drives the `req` line, waits for `grant`, and holds the lock for a programmed number of beats. It then releases the line and enforces an idle gap so the arbiter can rotate. A wait timeout ensures a starved requester reports an error instead of hanging.

---
 rtl/arb_requester.sv | 176 +++++++++++++++++
 tb/tb_arb_requester.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// arb_requester: requester-side agent for the 4-way priority-lock arbiter.
// Queues burst commands from a client, raises req, waits for grant, holds the
// lock for cmd_len+1 beats, then drops req for GAP_CYCLES so the arbiter can
// rotate. A requester that waits TIMEOUT cycles without any grant aborts the
// command and pulses timeout_err.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   cmd_valid    - command push request
//   cmd_len      - burst length minus one
//   cmd_ready    - command FIFO not full
//   req          - registered request line to the arbiter
//   grant        - this requester's grant bit
//   beat         - one data beat transferred this cycle
//   done         - final beat of a burst
//   timeout_err  - one-cycle pulse after a starved request is aborted
//   busy         - FSM not idle or FIFO not empty
module arb_requester #(
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             grant,
  output logic             beat,
  output logic             done,
  output logic             timeout_err,
  output logic             busy
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);

  localparam logic [PtrW-1:0]  PtrLast  = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StOwn, StGap} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic               req_q, err_q, abort;

  // Command FIFO
  logic [LEN_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             fifo_empty, push, pop;

  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != CntFull);
  assign push       = cmd_valid & cmd_ready;
  assign pop        = (state_q == StIdle) & ~fifo_empty;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end
  end

  // Payload storage needs no reset: occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_len;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter updates
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    wait_d   = wait_q;
    gap_d    = gap_q;
    abort    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d  = StReq;
          remain_d = mem_q[rd_ptr_q];
          wait_d   = '0;
        end
      end
      StReq: begin
        if (grant) begin
          if (remain_q == '0) begin
            state_d = StGap;
          end else begin
            remain_d = remain_q - LEN_W'(1);
            state_d  = StOwn;
          end
        end else if (wait_q == WaitLast) begin
          state_d = StGap;
          abort   = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StOwn: begin
        // Once owned, a withdrawn grant just stalls the burst; no timeout.
        if (grant) begin
          if (remain_q == '0) state_d = StGap;
          else                remain_d = remain_q - LEN_W'(1);
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          gap_d   = '0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers; req is registered from the next state so it is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain_q <= '0;
      wait_q   <= '0;
      gap_q    <= '0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      remain_q <= remain_d;
      wait_q   <= wait_d;
      gap_q    <= gap_d;
      req_q    <= (state_d == StReq) || (state_d == StOwn);
      err_q    <= abort;
    end
  end

  // Outputs
  always_comb begin
    beat        = grant & ((state_q == StReq) | (state_q == StOwn));
    done        = beat & (remain_q == '0);
    busy        = (state_q != StIdle) | ~fifo_empty;
    req         = req_q;
    timeout_err = err_q;
  end

endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;

  localparam int unsigned LEN_W      = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 16;
  localparam int unsigned GAP_CYCLES = 1;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             req;
  logic             grant;
  logic             beat;
  logic             done;
  logic             timeout_err;
  logic             busy;

  arb_requester #(
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_len     (cmd_len),
    .cmd_ready   (cmd_ready),
    .req         (req),
    .grant       (grant),
    .beat        (beat),
    .done        (done),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: pending command queue plus the burst in flight,
  // tracked as beats still owed, whether the lock was won, cycles waited
  // and idle-gap cycles still to serve.
  int mq[$];
  bit m_act, m_own, m_err;
  int m_left, m_wait, m_gap;
  bit can_push;
  int beat_cnt = 0, done_cnt = 0, err_cnt = 0, req_hi_cnt = 0;

  task automatic model_clear();
    mq.delete();
    m_act  = 1'b0;
    m_own  = 1'b0;
    m_err  = 1'b0;
    m_left = 0;
    m_wait = 0;
    m_gap  = 0;
  endtask

  task automatic model_step();
    can_push = cmd_valid && (mq.size() < FIFO_DEPTH);
    m_err = 1'b0;
    if (m_act) begin
      if (grant) begin
        m_left--;
        m_own = 1'b1;
        if (m_left == 0) begin
          m_act = 1'b0;
          m_gap = GAP_CYCLES;
        end
      end else if (!m_own) begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          m_act = 1'b0;
          m_gap = GAP_CYCLES;
          m_err = 1'b1;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (mq.size() > 0) begin
      m_left = mq.pop_front() + 1;
      m_act  = 1'b1;
      m_own  = 1'b0;
      m_wait = 0;
    end
    if (can_push) mq.push_back(int'(cmd_len));
  endtask

  // Compare process: inputs only change just after a rising edge, so at the
  // falling edge they hold the values the next rising edge will sample.
  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) model_clear();
      chk("req",         req,         m_act);
      chk("beat",        beat,        m_act && grant);
      chk("done",        done,        m_act && grant && (m_left == 1));
      chk("timeout_err", timeout_err, m_err);
      chk("busy",        busy,        m_act || (m_gap > 0) || (mq.size() > 0));
      chk("cmd_ready",   cmd_ready,   mq.size() < FIFO_DEPTH);
      if (rst_n) begin
        if (beat)        beat_cnt++;
        if (done)        done_cnt++;
        if (timeout_err) err_cnt++;
        if (req)         req_hi_cnt++;
        model_step();
      end
    end
  end

  // Arbiter stand-in: registered grant that follows req by one cycle.
  bit grant_en;
  bit last_req;

  task automatic tick();
    @(posedge clk);
    #1;
    grant     = grant_en & last_req;
    last_req  = req;
    cmd_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dones(input int target, input int limit, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      settle();
      if (done_cnt >= target) begin
        hit = 1'b1;
        break;
      end
    end
    chk({name, "_done_reached"}, hit, 1);
  endtask

  int b0, d0, e0, r0, nb;
  int ff_lens[6] = '{0, 1, 2, 0, 1, 3};

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    grant     = 1'b0;
    grant_en  = 1'b1;
    last_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_req",   req,       0);
    chk("rst_beat",  beat,      0);
    chk("rst_busy",  busy,      0);
    chk("rst_ready", cmd_ready, 1);

    // Single burst, len=3: push in cycle 1, req from cycle 3, done in cycle 7.
    b0 = beat_cnt; d0 = done_cnt;
    cmd_valid = 1'b1; cmd_len = 4'd3;
    tick(); #1;
    chk("sb_c2_req",  req,  0);
    chk("sb_c2_busy", busy, 1);
    tick(); #1;
    chk("sb_c3_req",  req,  1);
    chk("sb_c3_beat", beat, 0);
    tick(); #1;
    chk("sb_c4_beat", beat, 1);
    repeat (3) tick();
    #1;
    chk("sb_c7_done", done, 1);
    tick(); #1;
    chk("sb_c8_req",          req,  0);
    chk("sb_c8_busy",         busy, 1);
    chk("sb_gap_grant_ignored", beat, 0);
    tick(); #1;
    chk("sb_c9_busy", busy, 0);
    settle();
    chk("sb_beats", beat_cnt - b0, 4);
    chk("sb_dones", done_cnt - d0, 1);

    // Starvation: no grant, len=0 -> 16 req cycles then one timeout pulse.
    tick();
    grant_en = 1'b0;
    e0 = err_cnt; r0 = req_hi_cnt;
    cmd_valid = 1'b1; cmd_len = 4'd0;
    for (int i = 0; i < 40; i++) begin
      tick();
      settle();
      if (err_cnt > e0) break;
    end
    chk("stv_req_cycles", req_hi_cnt - r0, 16);
    chk("stv_req_low_at_err", req, 0);
    repeat (3) tick();
    settle();
    chk("stv_err_pulses", err_cnt - e0, 1);
    tick();
    grant_en = 1'b1;
    b0 = beat_cnt; d0 = done_cnt;
    cmd_valid = 1'b1; cmd_len = 4'd1;
    wait_dones(d0 + 1, 20, "stv_next");
    chk("stv_next_beats", beat_cnt - b0, 2);

    // Grant withdrawn for 3 cycles after beat 2 of a len=5 burst.
    repeat (3) tick();
    b0 = beat_cnt; d0 = done_cnt; e0 = err_cnt; nb = 0;
    cmd_valid = 1'b1; cmd_len = 4'd5;
    for (int i = 0; i < 20 && nb < 2; i++) begin
      tick(); #1;
      if (beat) nb++;
    end
    chk("stall_reached_beat2", nb, 2);
    grant_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("stall_req",  req,  1);
      chk("stall_beat", beat, 0);
    end
    grant_en = 1'b1;
    wait_dones(d0 + 1, 20, "stall");
    chk("stall_beats", beat_cnt - b0, 6);
    chk("stall_no_err", err_cnt - e0, 0);

    // FIFO full: six back-to-back pushes with no grant. The first leaves the
    // FIFO at once, the next four fill it, and the sixth (len=3) is dropped.
    repeat (3) tick();
    #1;
    chk("ff_idle_before", busy, 0);
    grant_en = 1'b0;
    b0 = beat_cnt; d0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(ff_lens[i]);
      if (i == 4) chk("ff_ready_before_full", cmd_ready, 1);
      if (i == 5) chk("ff_ready_full",        cmd_ready, 0);
      tick();
    end
    grant_en = 1'b1;
    wait_dones(d0 + 5, 100, "ff");
    chk("ff_beats", beat_cnt - b0, 9);
    repeat (10) tick();
    settle();
    chk("ff_dones", done_cnt - d0, 5);
    chk("ff_idle_after", busy, 0);

    // Reset during beat 2 of a len=7 burst.
    tick();
    cmd_valid = 1'b1; cmd_len = 4'd7;
    nb = 0;
    for (int i = 0; i < 20 && nb < 2; i++) begin
      tick(); #1;
      if (beat) nb++;
    end
    chk("mr_reached_beat2", nb, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_req",   req,         0);
    chk("mr_beat",  beat,        0);
    chk("mr_done",  done,        0);
    chk("mr_err",   timeout_err, 0);
    chk("mr_busy",  busy,        0);
    chk("mr_ready", cmd_ready,   1);
    tick();
    rst_n = 1'b1;
    b0 = beat_cnt;
    repeat (8) tick();
    settle();
    chk("mr_no_beats", beat_cnt - b0, 0);
    chk("mr_idle",     busy,          0);
    tick();
    b0 = beat_cnt; d0 = done_cnt;
    cmd_valid = 1'b1; cmd_len = 4'd2;
    wait_dones(d0 + 1, 20, "mr_new");
    chk("mr_new_beats", beat_cnt - b0, 3);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
